st7735_seq: RTL
===============

ST7735_SEQ -- requirements
Module: st7735_seq

Interface
REQ-001 SHALL have parameters: WIDTH, 128, pixel columns; HEIGHT, 160, pixel rows; RST_LOW_CYC, 120000, lcd_rst low time in clk cycles; RST_WAIT_CYC, 1440000, wait after lcd_rst release and after SLPOUT.
REQ-002 SHALL have ports, one clock and a synchronous active-low reset:
 clk  input  1  system clock
 resetn  input  1  synchronous active-low reset
 run  input  1  allow frame streaming; sampled only at frame boundary
 lcd_rst  output  1  display hardware reset, active low
 tx_byte  output  8  byte to SPI byte engine
 tx_dc  output  1  0 = command, 1 = data
 tx_valid  output  1  byte offered
 tx_ready  input  1  SPI engine accepts byte
 pix_data  input  16  RGB565 pixel
 pix_valid  input  1  pixel offered
 pix_ready  output  1  sequencer accepts pixel
 init_done  output  1  init sequence complete (sticky)
 frame_start  output  1  one-cycle pulse when RAMWR byte accepted

Function
REQ-003 SHALL implement states RST_LO, RST_WAIT, INIT, SLP_WAIT, IDLE, WIN, PIX_GET, PIX_HI, PIX_LO.
REQ-004 RST_LO: lcd_rst=0, count RST_LOW_CYC cycles, then RST_WAIT.
REQ-005 RST_WAIT: lcd_rst=1, count RST_WAIT_CYC cycles, then INIT at index 0.
REQ-006 INIT SHALL emit fixed list, (dc,byte): (0,11h) SLPOUT; then SLP_WAIT for RST_WAIT_CYC; then (0,3Ah),(1,05h),(0,36h),(1,00h),(0,29h); then IDLE with init_done=1.
REQ-007 Byte handshake: transfer occurs on clk edge with tx_valid=1 and tx_ready=1; tx_byte/tx_dc SHALL stay stable while tx_valid=1 and tx_ready=0; tx_valid SHALL never deassert without a transfer.
REQ-008 Next byte MAY be presented the cycle after a transfer (back-to-back allowed, one byte per cycle max).
REQ-009 IDLE: if run=1 go to WIN, else remain; tx_valid=0, pix_ready=0.
REQ-010 WIN SHALL emit 11 bytes: (0,2Ah),(1,00h),(1,00h),(1,00h),(1,WIDTH-1),(0,2Bh),(1,00h),(1,00h),(1,00h),(1,HEIGHT-1),(0,2Ch); frame_start pulses in the cycle after 2Ch transfers; then PIX_GET with pixel counter 0.
REQ-011 PIX_GET: pix_ready=1, tx_valid=0; on pix_valid&pix_ready latch pix_data, go PIX_HI.
REQ-012 PIX_HI: emit (1,pix[15:8]); on transfer go PIX_LO. PIX_LO: emit (1,pix[7:0]); on transfer increment counter.
REQ-013 Pixel counter width ceil(log2(WIDTH*HEIGHT)) bits; after PIX_LO transfer of pixel WIDTH*HEIGHT-1, counter clears to 0 and state goes IDLE; otherwise PIX_GET.
REQ-014 pix_ready SHALL be 1 only in PIX_GET; pix_valid outside PIX_GET SHALL be ignored (no latch).
REQ-015 run deassertion mid-frame SHALL NOT abort the frame; checked only in IDLE.
REQ-016 Delay counters SHALL be wide enough for max(RST_LOW_CYC,RST_WAIT_CYC); count N means exactly N cycles in the state.
REQ-017 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-018 While resetn=0 at a clk edge: state RST_LO, counters 0, lcd_rst=0, tx_valid=0, tx_dc=0, tx_byte=00h, pix_ready=0, init_done=0, frame_start=0.
REQ-019 resetn asserted mid-operation (including mid-handshake) SHALL abandon everything and restart full sequence from RST_LO after release; no partial byte resumed.

Verification (RST_LOW_CYC=4, RST_WAIT_CYC=6, WIDTH=2, HEIGHT=2)
REQ-020 Release resetn, tx_ready=1 -> lcd_rst low exactly 4 cycles, high, 6 cycles later tx_valid with (0,11h); 6-cycle gap then 3Ah,05h,36h,00h,29h; init_done=1.
REQ-021 run=1, tx_ready=1, pix_valid=1 with pixels F800h,07E0h,001Fh,FFFFh -> window bytes 2Ah,00,00,00,01,2Bh,00,00,00,01,2Ch; frame_start one pulse; data F8,00,07,E0,00,1F,FF,FF; return IDLE; next frame starts.
REQ-022 tx_ready toggled randomly during WIN/pixels -> byte stream identical to REQ-021, tx_byte/tx_dc stable while stalled, no byte dropped or duplicated.
REQ-023 pix_valid held 0 for 20 cycles in PIX_GET -> tx_valid=0 throughout, pix_ready=1, resumes correctly.
REQ-024 run dropped after second pixel -> frame completes all 4 pixels, stays IDLE, no 2Ah emitted.
REQ-025 resetn=0 during PIX_HI stall -> outputs per REQ-018 next edge; after release full init repeats from SLPOUT.

Source files
------------

// File: rtl/st7735_seq.sv
// ST7735 display sequencer: hardware reset, controller init list, then
// repeated full-screen frames (window setup + RAMWR + RGB565 pixel stream)
// presented one byte at a time to a downstream SPI byte engine.
module st7735_seq #(
    parameter int WIDTH        = 128,
    parameter int HEIGHT       = 160,
    parameter int RST_LOW_CYC  = 120000,
    parameter int RST_WAIT_CYC = 1440000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    output logic        lcd_rst,
    output logic [7:0]  tx_byte,
    output logic        tx_dc,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        init_done,
    output logic        frame_start
);

    localparam int MAX_DLY = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int CNT_W   = $clog2(MAX_DLY + 1);
    localparam int NPIX    = WIDTH * HEIGHT;
    localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);
    localparam logic [PIX_W-1:0] PIX_LAST      = PIX_W'(NPIX - 1);
    localparam logic [7:0]       X_END         = 8'(WIDTH - 1);
    localparam logic [7:0]       Y_END         = 8'(HEIGHT - 1);

    typedef enum logic [3:0] {
        RST_LO,
        RST_WAIT,
        INIT,
        SLP_WAIT,
        IDLE,
        WIN,
        PIX_GET,
        PIX_HI,
        PIX_LO
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [3:0]         idx;
    logic [PIX_W-1:0]   pix_cnt;
    logic [15:0]        pix;
    logic               xfer;

    assign xfer = tx_valid & tx_ready;

    // Init list as {dc, byte}; entry 0 (SLPOUT) is followed by the sleep-out wait
    function automatic logic [8:0] init_entry(input logic [3:0] i);
        case (i)
            4'd0:    init_entry = {1'b0, 8'h11};
            4'd1:    init_entry = {1'b0, 8'h3A};
            4'd2:    init_entry = {1'b1, 8'h05};
            4'd3:    init_entry = {1'b0, 8'h36};
            4'd4:    init_entry = {1'b1, 8'h00};
            default: init_entry = {1'b0, 8'h29};
        endcase
    endfunction

    // Full-screen window (CASET, RASET) followed by RAMWR, as {dc, byte}
    function automatic logic [8:0] win_entry(input logic [3:0] i);
        case (i)
            4'd0:    win_entry = {1'b0, 8'h2A};
            4'd1,
            4'd2,
            4'd3:    win_entry = {1'b1, 8'h00};
            4'd4:    win_entry = {1'b1, X_END};
            4'd5:    win_entry = {1'b0, 8'h2B};
            4'd6,
            4'd7,
            4'd8:    win_entry = {1'b1, 8'h00};
            4'd9:    win_entry = {1'b1, Y_END};
            default: win_entry = {1'b0, 8'h2C};
        endcase
    endfunction

    // Sequencer FSM; every output is a register loaded on the edge that enters
    // the state needing it, so tx_byte/tx_dc only move on a transfer edge
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= RST_LO;
            cnt         <= '0;
            idx         <= '0;
            pix_cnt     <= '0;
            pix         <= '0;
            lcd_rst     <= 1'b0;
            tx_valid    <= 1'b0;
            tx_dc       <= 1'b0;
            tx_byte     <= 8'h00;
            pix_ready   <= 1'b0;
            init_done   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                RST_LO: begin
                    if (cnt == RST_LOW_LAST) begin
                        state   <= RST_WAIT;
                        cnt     <= '0;
                        lcd_rst <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RST_WAIT: begin
                    if (cnt == RST_WAIT_LAST) begin
                        state            <= INIT;
                        cnt              <= '0;
                        idx              <= 4'd0;
                        {tx_dc, tx_byte} <= init_entry(4'd0);
                        tx_valid         <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                INIT: begin
                    if (xfer) begin
                        if (idx == 4'd0) begin
                            state    <= SLP_WAIT;
                            cnt      <= '0;
                            tx_valid <= 1'b0;
                        end else if (idx == 4'd5) begin
                            state     <= IDLE;
                            tx_valid  <= 1'b0;
                            init_done <= 1'b1;
                        end else begin
                            idx              <= idx + 4'd1;
                            {tx_dc, tx_byte} <= init_entry(idx + 4'd1);
                        end
                    end
                end
                SLP_WAIT: begin
                    if (cnt == RST_WAIT_LAST) begin
                        state            <= INIT;
                        cnt              <= '0;
                        idx              <= 4'd1;
                        {tx_dc, tx_byte} <= init_entry(4'd1);
                        tx_valid         <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (run) begin
                        state            <= WIN;
                        idx              <= 4'd0;
                        {tx_dc, tx_byte} <= win_entry(4'd0);
                        tx_valid         <= 1'b1;
                    end
                end
                WIN: begin
                    if (xfer) begin
                        if (idx == 4'd10) begin
                            state       <= PIX_GET;
                            tx_valid    <= 1'b0;
                            pix_ready   <= 1'b1;
                            frame_start <= 1'b1;
                            pix_cnt     <= '0;
                        end else begin
                            idx              <= idx + 4'd1;
                            {tx_dc, tx_byte} <= win_entry(idx + 4'd1);
                        end
                    end
                end
                PIX_GET: begin
                    if (pix_valid && pix_ready) begin
                        state     <= PIX_HI;
                        pix       <= pix_data;
                        pix_ready <= 1'b0;
                        tx_valid  <= 1'b1;
                        tx_dc     <= 1'b1;
                        tx_byte   <= pix_data[15:8];
                    end
                end
                PIX_HI: begin
                    if (xfer) begin
                        state   <= PIX_LO;
                        tx_byte <= pix[7:0];
                    end
                end
                PIX_LO: begin
                    if (xfer) begin
                        tx_valid <= 1'b0;
                        if (pix_cnt == PIX_LAST) begin
                            pix_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            pix_cnt   <= pix_cnt + PIX_W'(1);
                            state     <= PIX_GET;
                            pix_ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= RST_LO;
                    cnt      <= '0;
                    lcd_rst  <= 1'b0;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
